// File: rtl/cv32e40x_aes_share_sequencer.sv
// Sequencer feeding four chained masked saes32 byte ops to the FU.
// Optional AES_SEQ_REMASK_EN: re-split the shares with a fresh mask per byte op.
`timescale 1ns/1ps
module cv32e40x_aes_share_sequencer #(
    parameter logic [31:0] LFSR_POLY  = 32'h8020_0003,
    parameter logic [31:0] RESET_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] in_key,
    input  logic [1:0]  in_op,
    input  logic        seed_valid,
    input  logic [31:0] seed,
    output logic        fu_valid,
    input  logic        fu_ready,
    output logic [31:0] fu_rs1,
    output logic [31:0] fu_rs2,
    output logic [31:0] fu_rs3,
    output logic [1:0]  fu_bs,
    output logic        fu_op_encs,
    output logic        fu_op_encsm,
    output logic        fu_op_decs,
    output logic        fu_op_decsm,
    input  logic [31:0] fu_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_acc;
    logic [31:0] r_data;
    logic [31:0] r_mask;
    logic [31:0] r_lfsr;
    logic [1:0]  r_bs_cnt;
    logic [1:0]  r_op;

    logic        w_accept;
    logic        w_fu_done;
    logic        w_last;
    logic        w_step;
    logic [31:0] w_lfsr_nxt;

    assign w_accept   = in_valid & in_ready;
    assign w_fu_done  = (r_state == S_WAIT) & fu_ready;
    assign w_last     = (r_bs_cnt == 2'd3);
    assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]}
                      ^ (r_lfsr[0] ? LFSR_POLY : 32'h0);

`ifdef AES_SEQ_REMASK_EN
    assign w_step = w_accept | (w_fu_done & ~w_last);
`else
    assign w_step = w_accept;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        fu_valid    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fu_valid    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (fu_ready) begin
                    w_state_nxt = w_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= 32'h0;
            r_data   <= 32'h0;
            r_mask   <= 32'h0;
            r_bs_cnt <= 2'd0;
            r_op     <= 2'd0;
        end else if (w_accept) begin
            r_data   <= in_data;
            r_acc    <= in_key;
            r_op     <= in_op;
            r_bs_cnt <= 2'd0;
            r_mask   <= r_lfsr;
        end else if (w_fu_done) begin
            r_acc <= fu_rd;
            if (!w_last) begin
                r_bs_cnt <= r_bs_cnt + 2'd1;
`ifdef AES_SEQ_REMASK_EN
                r_mask   <= r_lfsr;
`endif
            end
        end
    end

    // A seed load wins over a same-cycle step; zero would lock the LFSR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= RESET_SEED;
        end else if (seed_valid) begin
            r_lfsr <= (seed == 32'h0) ? RESET_SEED : seed;
        end else if (w_step) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    always_comb begin
        fu_op_encs  = 1'b0;
        fu_op_encsm = 1'b0;
        fu_op_decs  = 1'b0;
        fu_op_decsm = 1'b0;
        if (r_state != S_IDLE) begin
            unique case (r_op)
                2'b00:   fu_op_encs  = 1'b1;
                2'b01:   fu_op_encsm = 1'b1;
                2'b10:   fu_op_decs  = 1'b1;
                default: fu_op_decsm = 1'b1;
            endcase
        end
    end

    assign fu_rs1   = r_acc;
    assign fu_rs2   = r_data ^ r_mask;
    assign fu_rs3   = r_mask;
    assign fu_bs    = r_bs_cnt;
    assign out_data = r_acc;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_cv32e40x_aes_share_sequencer.sv
// Directed bench for cv32e40x_aes_share_sequencer with a recombining saes32 FU model.
`timescale 1ns/1ps
module tb_cv32e40x_aes_share_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] in_key = '0;
    logic [1:0]  in_op = '0;
    logic        seed_valid = 1'b0;
    logic [31:0] seed = '0;
    logic        fu_valid;
    logic        fu_ready;
    logic [31:0] fu_rs1, fu_rs2, fu_rs3;
    logic [1:0]  fu_bs;
    logic        fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm;
    logic [31:0] fu_rd;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    int          fu_lat = 2;
    logic [31:0] job_data = '0;
    int          pulses, unstable, inv_err;
    logic [1:0]  bs_log[$];
    logic [31:0] rs3_log[$];

    cv32e40x_aes_share_sequencer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .in_op(in_op),
        .seed_valid(seed_valid), .seed(seed),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_rs3(fu_rs3),
        .fu_bs(fu_bs),
        .fu_op_encs(fu_op_encs), .fu_op_encsm(fu_op_encsm),
        .fu_op_decs(fu_op_decs), .fu_op_decsm(fu_op_decsm),
        .fu_rd(fu_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] a);
        return ginv(rol8(a, 1) ^ rol8(a, 3) ^ rol8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] fu_calc(
        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] rs3,
        input logic [1:0] bs, input logic [3:0] ops);
        logic [31:0] d, u;
        logic [7:0]  x, s;
        logic [63:0] t;
        d = rs2 ^ rs3;
        x = d[int'(bs)*8 +: 8];
        s = (ops[1] | ops[0]) ? isbox(x) : sbox(x);
        if (ops[2])
            u = {gmul(s, 8'h03), s, s, gmul(s, 8'h02)};
        else if (ops[0])
            u = {gmul(s, 8'h0b), gmul(s, 8'h0d), gmul(s, 8'h09), gmul(s, 8'h0e)};
        else
            u = {24'h0, s};
        t = {u, u} << (int'(bs) * 8);
        return (ops == 4'b0000) ? rs1 : (rs1 ^ t[63:32]);
    endfunction

    // FU model: responds fu_lat cycles after each issue, acting 2ns after the edge.
    initial begin
        logic [101:0] c_ops;
        logic [31:0]  c_rd;
        int           cnt;
        fu_ready = 1'b0;
        fu_rd = '0;
        cnt = 0;
        c_ops = '0;
        c_rd = '0;
        forever begin
            @(posedge clk);
            #2;
            fu_ready = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (fu_valid) begin
                pulses++;
                bs_log.push_back(fu_bs);
                rs3_log.push_back(fu_rs3);
                if ((fu_rs2 ^ fu_rs3) !== job_data) inv_err++;
                c_ops = {fu_rs1, fu_rs2, fu_rs3, fu_bs,
                         fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm};
                c_rd = fu_calc(fu_rs1, fu_rs2, fu_rs3, fu_bs,
                               {fu_op_encs, fu_op_encsm, fu_op_decs, fu_op_decsm});
                cnt = fu_lat;
            end else if (cnt > 0) begin
                if ({fu_rs1, fu_rs2, fu_rs3, fu_bs, fu_op_encs, fu_op_encsm,
                     fu_op_decs, fu_op_decsm} !== c_ops) unstable++;
                cnt--;
                if (cnt == 0) begin
                    fu_ready = 1'b1;
                    fu_rd = c_rd;
                end
            end
        end
    end

    task automatic clear_logs();
        pulses = 0;
        unstable = 0;
        inv_err = 0;
        bs_log.delete();
        rs3_log.delete();
    endtask

    task automatic do_job(input logic [31:0] d, input logic [31:0] k,
                          input logic [1:0] op, input int lat, input int hold,
                          output logic [31:0] res, output int cyc, output int st);
        logic [31:0] snap;
        clear_logs();
        fu_lat = lat;
        job_data = d;
        st = 0;
        in_valid = 1'b1;
        in_data = d;
        in_key = k;
        in_op = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            if (in_ready) st++;
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL job_timeout: out_valid=0 after %0d cycles, required 1", cyc);
        end
        snap = out_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || out_data !== snap || in_ready) st++;
        end
        res = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (!in_ready || out_valid || busy) st++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if ({in_ready, fu_valid, out_valid, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 1000",
                     {in_ready, fu_valid, out_valid, busy});
        end
        n_checks++;
        if ({fu_rs1, fu_rs2, fu_rs3, fu_bs, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: rs1=%h rs2=%h rs3=%h bs=%0d out=%h required all 0",
                     fu_rs1, fu_rs2, fu_rs3, fu_bs, out_data);
        end
    endtask

    task automatic test_encs();
        logic [31:0] r;
        int cyc, st;
        do_job(32'h0, 32'h0, 2'b00, 2, 0, r, cyc, st);
        n_checks++;
        if (r !== 32'h6363_6363) begin
            n_fail++;
            $display("FAIL encs_data: got %h required 63636363", r);
        end
        n_checks++;
        if (pulses !== 4) begin
            n_fail++;
            $display("FAIL encs_pulses: got %0d required 4", pulses);
        end
        n_checks++;
        if (bs_log.size() != 4 ||
            {bs_log[3], bs_log[2], bs_log[1], bs_log[0]} !== 8'hE4) begin
            n_fail++;
            $display("FAIL encs_bs_seq: got %0d entries, seq mismatch, required 0,1,2,3",
                     bs_log.size());
        end
        n_checks++;
        if (cyc !== 13) begin
            n_fail++;
            $display("FAIL encs_latency: got %0d required 13", cyc);
        end
        n_checks++;
        if (rs3_log.size() == 0 || rs3_log[0] !== 32'h1) begin
            n_fail++;
            $display("FAIL encs_reset_mask: got %h required 00000001",
                     rs3_log.size() == 0 ? 32'hx : rs3_log[0]);
        end
        n_checks++;
        if (inv_err !== 0 || unstable !== 0 || st !== 0) begin
            n_fail++;
            $display("FAIL encs_protocol: inv=%0d unstable=%0d stall=%0d required 0,0,0",
                     inv_err, unstable, st);
        end
    endtask

    task automatic test_encsm();
        logic [31:0] r;
        int cyc, st;
        do_job(32'h0, 32'h0, 2'b01, 2, 0, r, cyc, st);
        n_checks++;
        if (r !== 32'h6363_6363) begin
            n_fail++;
            $display("FAIL encsm_data: got %h required 63636363", r);
        end
    endtask

    task automatic test_decs();
        logic [31:0] r;
        int cyc, st;
        do_job(32'h6363_6363, 32'h0, 2'b10, 2, 0, r, cyc, st);
        n_checks++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL decs_data: got %h required 00000000", r);
        end
        n_checks++;
        if (inv_err !== 0) begin
            n_fail++;
            $display("FAIL decs_share_invariant: got %0d errors required 0", inv_err);
        end
    endtask

    task automatic test_key();
        logic [31:0] r;
        int cyc, st;
        do_job(32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 2, 0, r, cyc, st);
        n_checks++;
        if (r !== 32'h9C9C_9C83) begin
            n_fail++;
            $display("FAIL key_data: got %h required 9c9c9c83", r);
        end
    endtask

    task automatic test_stall();
        logic [31:0] r;
        int cyc, st;
        do_job(32'h0, 32'h0, 2'b01, 1, 3, r, cyc, st);
        n_checks++;
        if (r !== 32'h6363_6363 || cyc !== 9) begin
            n_fail++;
            $display("FAIL lat1_job: data=%h cyc=%0d required 63636363 9", r, cyc);
        end
        n_checks++;
        if (st !== 0 || unstable !== 0) begin
            n_fail++;
            $display("FAIL lat1_hold: stall=%0d unstable=%0d required 0 0", st, unstable);
        end
        do_job(32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 5, 3, r, cyc, st);
        n_checks++;
        if (r !== 32'h9C9C_9C83 || cyc !== 25) begin
            n_fail++;
            $display("FAIL lat5_job: data=%h cyc=%0d required 9c9c9c83 25", r, cyc);
        end
        n_checks++;
        if (st !== 0 || unstable !== 0) begin
            n_fail++;
            $display("FAIL lat5_hold: stall=%0d unstable=%0d required 0 0", st, unstable);
        end
    endtask

    task automatic test_seed();
        logic [31:0]  r;
        logic [127:0] got, exp;
        int cyc, st;
        seed_valid = 1'b1;
        seed = 32'h0;
        @(posedge clk); #1;
        seed_valid = 1'b0;
        do_job(32'h0, 32'h0, 2'b00, 2, 0, r, cyc, st);
        n_checks++;
        if (rs3_log.size() == 0 || rs3_log[0] !== 32'h1 || r !== 32'h6363_6363) begin
            n_fail++;
            $display("FAIL seed_zero: mask=%h data=%h required 00000001 63636363",
                     rs3_log.size() == 0 ? 32'hx : rs3_log[0], r);
        end
        seed_valid = 1'b1;
        seed = 32'h1234_5678;
        @(posedge clk); #1;
        seed_valid = 1'b0;
        do_job(32'hA5A5_0F0F, 32'h0, 2'b00, 2, 0, r, cyc, st);
`ifdef AES_SEQ_REMASK_EN
        exp = {32'h0246_8ACF, 32'h048D_159E, 32'h091A_2B3C, 32'h1234_5678};
`else
        exp = {32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
`endif
        got = (rs3_log.size() == 4) ?
              {rs3_log[3], rs3_log[2], rs3_log[1], rs3_log[0]} : 'x;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL seed_masks: got %h required %h", got, exp);
        end
        n_checks++;
        if (inv_err !== 0) begin
            n_fail++;
            $display("FAIL seed_share_invariant: got %0d errors required 0", inv_err);
        end
        do_job(32'h0, 32'h0, 2'b00, 2, 0, r, cyc, st);
`ifdef AES_SEQ_REMASK_EN
        exp[31:0] = 32'h8103_4564;
`else
        exp[31:0] = 32'h091A_2B3C;
`endif
        n_checks++;
        if (rs3_log.size() == 0 || rs3_log[0] !== exp[31:0]) begin
            n_fail++;
            $display("FAIL seed_next_mask: got %h required %h",
                     rs3_log.size() == 0 ? 32'hx : rs3_log[0], exp[31:0]);
        end
    endtask

    task automatic test_reset_midjob();
        logic [31:0] r;
        int cyc, st, n, bad;
        clear_logs();
        fu_lat = 3;
        job_data = 32'h0;
        in_valid = 1'b1;
        in_data = 32'h0;
        in_key = 32'h0;
        in_op = 2'b00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!(busy && !fu_valid && fu_bs == 2'd2) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL midjob_reach_op2: waited %0d cycles, bound 100", n);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({busy, out_valid, in_ready} !== 3'b001 || fu_rs1 !== 32'h0) begin
            n_fail++;
            $display("FAIL midjob_abort: busy/ov/ir=%b rs1=%h required 001 00000000",
                     {busy, out_valid, in_ready}, fu_rs1);
        end
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid || busy) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midjob_quiet: got %0d active cycles required 0", bad);
        end
        do_job(32'h0, 32'h0, 2'b00, 2, 0, r, cyc, st);
        n_checks++;
        if (r !== 32'h6363_6363 || cyc !== 13) begin
            n_fail++;
            $display("FAIL midjob_rerun: data=%h cyc=%0d required 63636363 13", r, cyc);
        end
        n_checks++;
        if (rs3_log.size() == 0 || rs3_log[0] !== 32'h1) begin
            n_fail++;
            $display("FAIL midjob_seed_restore: got %h required 00000001",
                     rs3_log.size() == 0 ? 32'hx : rs3_log[0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_encs();
        test_encsm();
        test_decs();
        test_key();
        test_stall();
        test_seed();
        test_reset_midjob();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
